// File: rtl/sipo_comma_align_10bit.sv
// sipo_comma_align_10bit: serial-to-parallel 10-bit deserializer with K28.5 comma word alignment
// Optional: define SIPO_ALIGN_ERR_CNT_EN to add the err_cnt realign counter output.
module sipo_comma_align_10bit #(
    parameter int          LOCK_CNT = 2,
    parameter logic [9:0]  COMMA_M  = 10'h17C,
    parameter logic [9:0]  COMMA_P  = 10'h283
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ser_in,
    input  logic       ser_valid,
    output logic [9:0] par_out,
    output logic       par_valid,
    output logic       is_comma,
    output logic       locked,
    output logic       realign
`ifdef SIPO_ALIGN_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);
    typedef enum logic [1:0] {HUNT, SYNC, LOCK} state_t;

    localparam logic [3:0] LC = 4'(LOCK_CNT);

    state_t     state, state_nx;
    logic [9:0] window;
    logic [3:0] fill, bit_cnt, good, good_nx;
    logic       ev, bnd, match, emit, move, slip;

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= HUNT;
            good  <= 4'd0;
        end else begin
            state <= state_nx;
            good  <= good_nx;
        end
    end

    // next state: only emissions can move the FSM; non-comma words leave it alone
    always_comb begin
        good_nx  = move ? 4'd1 : (bnd && match && good < LC) ? good + 4'd1 : good;
        state_nx = !emit ? state : slip ? SYNC : (good_nx >= LC) ? LOCK : SYNC;
    end

    // decode: ev marks a freshly formed window, bnd marks one that lands on the boundary
    always_comb begin
        match  = ev && (window == COMMA_M || window == COMMA_P);
        move   = match && (state == HUNT || !bnd);
        slip   = move && state != HUNT;
        emit   = move || (bnd && state != HUNT);
        locked = state == LOCK;
    end

    // shift window, track fill and boundary position, register emitted word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            window    <= 10'd0;
            fill      <= 4'd0;
            bit_cnt   <= 4'd0;
            ev        <= 1'b0;
            bnd       <= 1'b0;
            par_out   <= 10'd0;
            par_valid <= 1'b0;
            is_comma  <= 1'b0;
            realign   <= 1'b0;
        end else begin
            if (ser_valid)
                window <= {ser_in, window[9:1]};
            fill      <= (ser_valid && fill != 4'd10) ? fill + 4'd1 : fill;
            ev        <= ser_valid && fill >= 4'd9;
            bit_cnt   <= move ? {3'b0, ser_valid} : !ser_valid ? bit_cnt : (bit_cnt == 4'd9) ? 4'd0 : bit_cnt + 4'd1;
            bnd       <= ser_valid && !move && state != HUNT && bit_cnt == 4'd9;
            par_valid <= emit;
            is_comma  <= emit && match;
            realign   <= slip;
            if (emit)
                par_out <= window;
        end
    end

`ifdef SIPO_ALIGN_ERR_CNT_EN
    // saturating count of boundary moves after initial acquisition
    always_ff @(posedge clk) begin
        if (!rst_n)
            err_cnt <= 8'd0;
        else if (slip && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`endif
endmodule
